stream_sink_checker: RTL and testbench

//  Consumer end of the team's 32-bit valid/ready stream: the block that sits downstream of a pipeline register.

---
 rtl/stream_pkg.sv | 15 +
 rtl/stream_bp_pattern.sv | 28 ++
 rtl/stream_sink_checker.sv | 142 ++++++++++++++
 tb/tb_stream_sink_checker.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared stream types and default widths for the sink checker and its matching source.
// No logic; imported by every stream block.
package stream_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_CNT_W  = 16;
   localparam int DEF_PAT_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } sink_state_t;

endpackage

// File: rtl/stream_bp_pattern.sv
// Rotating backpressure pattern: load wins over enable, rotates right by one per enabled cycle.
// Stall bit is the registered LSB, so it has no combinational path from any input.
module stream_bp_pattern #(
   parameter int PAT_W = 8
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [PAT_W-1:0] load_pat,
   input  logic             en,
   output logic             stall
);

   logic [PAT_W-1:0] pat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat <= '0;
      end else if (load) begin
         pat <= load_pat;
      end else if (en) begin
         pat <= {pat[0], pat[PAT_W-1:1]};
      end
   end

   assign stall = pat[0];

endmodule

// File: rtl/stream_sink_checker.sv
// Stream sink/checker: programmable backpressure, incrementing-sequence check, beat/error counts.
// in_ready is registered-state only; optional idle watchdog under STREAM_SINK_TIMEOUT_EN.
module stream_sink_checker
   import stream_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int PAT_W   = DEF_PAT_W,
   parameter int TIMEOUT = 1024
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_beats,
   input  logic [DATA_W-1:0] seed,
   input  logic [PAT_W-1:0]  stall_pat,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  beat_cnt,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [DATA_W-1:0] first_err,
   output logic              timeout
);

   sink_state_t       state, state_nxt;
   logic              start_ok;
   logic              hs;
   logic              last_beat;
   logic              stall;
   logic              to_hit;
   logic [CNT_W-1:0]  target;
   logic [CNT_W-1:0]  beat_nxt;
   logic [DATA_W-1:0] exp_dat;

   assign start_ok  = start & (state != ST_RUN);
   assign in_ready  = (state == ST_RUN) & ~stall;
   assign hs        = in_valid & in_ready;
   assign beat_nxt  = beat_cnt + CNT_W'(1);
   assign last_beat = hs & (beat_nxt == target);
   assign busy      = (state == ST_RUN);
   assign done      = (state == ST_DONE);

   stream_bp_pattern #(
      .PAT_W (PAT_W)
   ) u_bp_pattern (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (start_ok),
      .load_pat (stall_pat),
      .en       (state == ST_RUN),
      .stall    (stall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: begin
            // A zero-length run skips RUN entirely.
            if (start) begin
               state_nxt = (num_beats == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (last_beat || to_hit) begin
               state_nxt = ST_DONE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt  <= '0;
         err_cnt   <= '0;
         first_err <= '0;
         exp_dat   <= '0;
         target    <= '0;
      end else if (start_ok) begin
         beat_cnt  <= '0;
         err_cnt   <= '0;
         first_err <= '0;
         exp_dat   <= seed;
         target    <= num_beats;
      end else if (hs) begin
         beat_cnt <= beat_nxt;
         exp_dat  <= exp_dat + DATA_W'(1);
         if (in_data != exp_dat) begin
            if (err_cnt != '1) begin
               err_cnt <= err_cnt + CNT_W'(1);
            end
            if (err_cnt == '0) begin
               first_err <= in_data;
            end
         end
      end
   end

`ifdef STREAM_SINK_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   logic [IDLE_W-1:0] idle_cnt;

   // A handshake in the limit cycle wins: the run continues and the counter clears.
   assign to_hit = (state == ST_RUN) & ~hs & (idle_cnt == IDLE_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt <= '0;
         timeout  <= 1'b0;
      end else if (start_ok) begin
         idle_cnt <= '0;
         timeout  <= 1'b0;
      end else if (state != ST_RUN || hs) begin
         idle_cnt <= '0;
      end else if (to_hit) begin
         idle_cnt <= '0;
         timeout  <= 1'b1;
      end else begin
         idle_cnt <= idle_cnt + IDLE_W'(1);
      end
   end
`else
   logic [31:0] timeout_unused;

   assign timeout_unused = 32'(TIMEOUT);
   assign to_hit         = 1'b0;
   assign timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_stream_sink_checker.sv
// Directed bench for stream_sink_checker; timeout scenario needs STREAM_SINK_TIMEOUT_EN.
module tb_stream_sink_checker;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        start;
   logic [15:0] num_beats;
   logic [31:0] seed;
   logic [7:0]  stall_pat;
   logic        busy;
   logic        done;
   logic [15:0] beat_cnt;
   logic [15:0] err_cnt;
   logic [31:0] first_err;
   logic        timeout;

   int          checks;
   int          failures;
   logic [31:0] src_dat [8];
   logic [15:0] rdy_hist;
   logic [31:0] acc_q [$];

   stream_sink_checker #(
      .DATA_W  (32),
      .CNT_W   (16),
      .PAT_W   (8),
      .TIMEOUT (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .start     (start),
      .num_beats (num_beats),
      .seed      (seed),
      .stall_pat (stall_pat),
      .busy      (busy),
      .done      (done),
      .beat_cnt  (beat_cnt),
      .err_cnt   (err_cnt),
      .first_err (first_err),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic do_start(input logic [31:0] s, input logic [15:0] nb, input logic [7:0] p);
      seed      = s;
      num_beats = nb;
      stall_pat = p;
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
   endtask

   // Source: presents src_dat[0..n-1] in order, advancing only on handshake.
   task automatic run_source(input int n, input int max_cyc);
      int sent;
      sent     = 0;
      rdy_hist = '0;
      acc_q.delete();
      for (int c = 0; c < max_cyc; c++) begin
         in_valid = (sent < n);
         in_data  = (sent < 8) ? src_dat[sent] : 32'h0;
         @(negedge clk);
         if (c < 16) rdy_hist[c] = in_ready;
         if (in_valid && in_ready) begin
            acc_q.push_back(in_data);
            sent++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid  = 1'($urandom);
         in_data   = $urandom;
         start     = 1'($urandom);
         num_beats = 16'($urandom);
         seed      = $urandom;
         stall_pat = 8'($urandom);
         @(negedge clk);
         if ({in_ready, busy, done, timeout} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0000", {in_ready, busy, done, timeout});
         end
         checks++;
         if ({beat_cnt, err_cnt, first_err} !== 64'h0) begin
            failures++;
            $display("FAIL reset_counters: got %h expected 0", {beat_cnt, err_cnt, first_err});
         end
         checks++;
      end
      in_valid = 1'b0; in_data = '0; start = 1'b0; num_beats = '0; seed = '0; stall_pat = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_clean_run();
      for (int i = 0; i < 4; i++) src_dat[i] = 32'hACCEDED0 + 32'(i);
      do_start(32'hACCEDED0, 16'd4, 8'h00);
      run_source(4, 6);
      if (rdy_hist[5:0] !== 6'b001111) begin
         failures++;
         $display("FAIL clean_ready_pattern: got %b expected 001111", rdy_hist[5:0]);
      end
      checks++;
      if ({beat_cnt, err_cnt} !== {16'd4, 16'd0}) begin
         failures++;
         $display("FAIL clean_counts: got beat=%0d err=%0d expected beat=4 err=0", beat_cnt, err_cnt);
      end
      checks++;
      if ({done, busy, in_ready, timeout} !== 4'b1000) begin
         failures++;
         $display("FAIL clean_done: got %b expected 1000", {done, busy, in_ready, timeout});
      end
      checks++;
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 8; i++) src_dat[i] = 32'h0000_1000 + 32'(i);
      do_start(32'h0000_1000, 16'd6, 8'b0000_0101);
      run_source(6, 10);
      if (rdy_hist[9:0] !== 10'b00_1111_1010) begin
         failures++;
         $display("FAIL bp_ready_pattern: got %b expected 0011111010", rdy_hist[9:0]);
      end
      checks++;
      if (acc_q.size() != 6) begin
         failures++;
         $display("FAIL bp_hs_count: got %0d expected 6", acc_q.size());
      end
      checks++;
      for (int i = 0; i < acc_q.size(); i++) begin
         if (acc_q[i] !== 32'h0000_1000 + 32'(i)) begin
            failures++;
            $display("FAIL bp_scoreboard[%0d]: got %h expected %h", i, acc_q[i], 32'h0000_1000 + 32'(i));
         end
         checks++;
      end
      if ({beat_cnt, err_cnt, 15'h0, done} !== {16'd6, 16'd0, 16'd1}) begin
         failures++;
         $display("FAIL bp_result: got beat=%0d err=%0d done=%b expected 6 0 1", beat_cnt, err_cnt, done);
      end
      checks++;
   endtask

   task automatic test_mismatch();
      src_dat[0] = 32'h0; src_dat[1] = 32'h7; src_dat[2] = 32'h9;
      do_start(32'h0, 16'd3, 8'h00);
      run_source(3, 5);
      if ({beat_cnt, err_cnt} !== {16'd3, 16'd2}) begin
         failures++;
         $display("FAIL mm_counts: got beat=%0d err=%0d expected beat=3 err=2", beat_cnt, err_cnt);
      end
      checks++;
      if (first_err !== 32'h7) begin
         failures++;
         $display("FAIL mm_first_err: got %h expected 00000007", first_err);
      end
      checks++;
   endtask

   task automatic test_wrap_edge();
      src_dat[0] = 32'hFFFF_FFFF; src_dat[1] = 32'h0000_0000;
      do_start(32'hFFFF_FFFF, 16'd2, 8'h00);
      run_source(2, 4);
      if ({beat_cnt, err_cnt, first_err} !== {16'd2, 16'd0, 32'h0}) begin
         failures++;
         $display("FAIL wrap_result: got beat=%0d err=%0d first=%h expected 2 0 0", beat_cnt, err_cnt, first_err);
      end
      checks++;
      do_start(32'h1234, 16'd0, 8'h00);
      if ({done, busy, in_ready, beat_cnt} !== {3'b100, 16'd0}) begin
         failures++;
         $display("FAIL zero_beats: got done=%b busy=%b rdy=%b beat=%0d expected 1 0 0 0",
                  done, busy, in_ready, beat_cnt);
      end
      checks++;
      // Second start during RUN with conflicting arguments must change nothing.
      do_start(32'h50, 16'd3, 8'h00);
      do_start(32'h999, 16'd0, 8'hFF);
      if ({busy, done} !== 2'b10) begin
         failures++;
         $display("FAIL start_in_run_state: got busy=%b done=%b expected 1 0", busy, done);
      end
      checks++;
      src_dat[0] = 32'h50; src_dat[1] = 32'h51; src_dat[2] = 32'h52;
      run_source(3, 5);
      if ({beat_cnt, err_cnt, 15'h0, done} !== {16'd3, 16'd0, 16'd1}) begin
         failures++;
         $display("FAIL start_in_run_result: got beat=%0d err=%0d done=%b expected 3 0 1", beat_cnt, err_cnt, done);
      end
      checks++;
   endtask

`ifdef STREAM_SINK_TIMEOUT_EN
   task automatic test_timeout();
      int k;
      logic seen_rdy;
      k = 0;
      seen_rdy = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'h0;
      do_start(32'h0, 16'd2, 8'hFF);
      while (!done && k < 40) begin
         if (in_ready) seen_rdy = 1'b1;
         @(posedge clk); #1;
         k++;
      end
      in_valid = 1'b0;
      if (k != 16) begin
         failures++;
         $display("FAIL to_latency: got %0d cycles expected 16", k);
      end
      checks++;
      if ({done, timeout, seen_rdy, beat_cnt} !== {3'b110, 16'd0}) begin
         failures++;
         $display("FAIL to_flags: got done=%b to=%b rdy_seen=%b beat=%0d expected 1 1 0 0",
                  done, timeout, seen_rdy, beat_cnt);
      end
      checks++;
   endtask
`endif

   task automatic test_reset_mid_run();
      src_dat[0] = 32'h0; src_dat[1] = 32'h5;
      do_start(32'h0, 16'd5, 8'h00);
      run_source(2, 2);
      if ({busy, beat_cnt, err_cnt, first_err} !== {1'b1, 16'd2, 16'd1, 32'h5}) begin
         failures++;
         $display("FAIL mid_run_pre: got busy=%b beat=%0d err=%0d first=%h expected 1 2 1 5",
                  busy, beat_cnt, err_cnt, first_err);
      end
      checks++;
      #2;
      rst_n = 1'b0;
      #1;
      if ({in_ready, busy, done, timeout, beat_cnt, err_cnt, first_err} !== 68'h0) begin
         failures++;
         $display("FAIL mid_run_reset: got rdy=%b busy=%b done=%b to=%b beat=%0d err=%0d first=%h expected all 0",
                  in_ready, busy, done, timeout, beat_cnt, err_cnt, first_err);
      end
      checks++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      start    = 1'b0;
      num_beats = '0;
      seed     = '0;
      stall_pat = '0;
      for (int i = 0; i < 8; i++) src_dat[i] = '0;
      #1;
      test_reset();
      test_clean_run();
      test_backpressure();
      test_mismatch();
      test_wrap_edge();
`ifdef STREAM_SINK_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
